// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared state, exception and latency-bound definitions for the data memory
package data_memory_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  typedef enum logic [1:0] {EXC_NONE = 2'b00, EXC_RANGE = 2'b01, EXC_BYTE_EN = 2'b10} exc_t;
  localparam int MIN_RD_LAT = 1;
  localparam int MAX_RD_LAT = 4;
endpackage

// File: rtl/data_memory_array.sv
// data_memory_array: word storage with byte-enabled synchronous write and combinational read
module data_memory_array #(
  parameter int IW = 10,
  parameter int DW = 16,
  parameter int SIZE = 1024,
  parameter int BW = DW / 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [BW-1:0] be,
  input  logic [IW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [IW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [SIZE];
  always_ff @(posedge clk)
    for (int i = 0; i < BW; i++)
      if (we && be[i]) mem[wr_addr][8*i+:8] <= wr_data[8*i+:8];
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/data_memory_sync.sv
// data_memory_sync: handshaked data memory with configurable read latency and exception reporting
module data_memory_sync
  import data_memory_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_SIZE = 1024,
  parameter int READ_LATENCY = 2,
  parameter int BE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       write,
  input  logic [DATA_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [BE_WIDTH-1:0]        byte_en,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [1:0]                 exception
);
  localparam int IW = DATA_SIZE > 1 ? $clog2(DATA_SIZE) : 1;
  if (READ_LATENCY < MIN_RD_LAT || READ_LATENCY > MAX_RD_LAT || DATA_WIDTH % 8 != 0)
    $error("data_memory_sync: illegal parameters");
  state_t state, state_d;
  exc_t exc_c;
  logic [1:0] cnt;
  logic [IW-1:0] addr_q, rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic accept, we;
  assign req_ready = state == ST_IDLE;
  assign resp_valid = state == ST_RESP;
  assign accept = req_valid && req_ready;
  assign exc_c = 32'(addr) >= 32'(DATA_SIZE) ? EXC_RANGE :
                 (write && byte_en == '0) ? EXC_BYTE_EN : EXC_NONE;
  assign we = accept && write && exc_c == EXC_NONE;
  assign rd_addr = state == ST_IDLE ? addr[IW-1:0] : addr_q;
  always_comb begin
    state_d = state;
    if (state == ST_IDLE && accept)
      state_d = (exc_c != EXC_NONE || write || READ_LATENCY == 1) ? ST_RESP : ST_WAIT;
    else if (state == ST_WAIT)
      state_d = cnt == '0 ? ST_RESP : ST_WAIT;
    else if (state == ST_RESP)
      state_d = resp_ready ? ST_IDLE : ST_RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      addr_q <= '0;
      data_out <= '0;
      exception <= EXC_NONE;
    end else begin
      state <= state_d;
      if (accept) begin
        addr_q <= addr[IW-1:0];
        exception <= exc_c;
        cnt <= 2'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
        data_out <= (exc_c == EXC_NONE && !write && READ_LATENCY == 1) ? rd_data : '0;
      end else if (state == ST_WAIT) begin
        if (cnt == '0) data_out <= rd_data;
        else cnt <= cnt - 2'd1;
      end
    end
  data_memory_array #(.IW(IW), .DW(DATA_WIDTH), .SIZE(DATA_SIZE), .BW(BE_WIDTH)) u_array (
    .clk(clk),
    .we(we),
    .be(byte_en),
    .wr_addr(addr[IW-1:0]),
    .wr_data(data_in),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule

// File: doc/data_memory_sync.md
Name: data_memory_sync

Overview:
- Clocked, parametrised successor to the combinational data memory used by the CPU datapath.
- Adds a valid/ready request/response handshake and a configurable read latency.
- Adds per-byte write enables and classified exceptions: out-of-range and byte-enable misuse.
- Sits between the load/store unit and word-addressed data storage, with one outstanding request at a time.

Parameters:
- DATA_ADDR_WIDTH, 16: width of the word address.
- DATA_WIDTH, 16: data word width. Must be a multiple of 8.
- DATA_SIZE, 1024: number of words. Valid addresses are 0..DATA_SIZE-1.
- READ_LATENCY, 2: cycles from the accept edge to read data. Legal range is 1..4.
- BE_WIDTH, DATA_WIDTH/8: number of byte-enable bits (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- write  in  1  1 = store, 0 = load.
- addr  in  DATA_ADDR_WIDTH  word address.
- data_in  in  DATA_WIDTH  store data.
- byte_en  in  BE_WIDTH  store byte lanes. Bit i covers data_in[8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- data_out  out  DATA_WIDTH  load data. 0 for stores and exceptions.
- exception  out  2  00 none, 01 address >= DATA_SIZE, 10 store with byte_en == 0.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, req_ready=1, resp_valid=0, data_out=0, exception=00, latency counter=0.
  - Memory contents are not cleared. A read of a never-written word returns X, and the bench must not check it.
- States: IDLE, WAIT, RESP.
- req_ready=1 only in IDLE. A request is accepted on a rising edge E where req_valid & req_ready.
- Request fields (write/addr/data_in/byte_en) are sampled only at E. Later changes are ignored.
- Exception priority: range check first (01), then zero byte_en on a store (10). Loads ignore byte_en.
  - An excepting request never touches memory.
  - Goes IDLE->RESP at E with exception set, data_out=0; resp_valid=1 in the cycle after E.
- Store without exception: lanes with byte_en=1 are written at E; other lanes are unchanged. IDLE->RESP at E with data_out=0, exception=00.
- Load without exception, READ_LATENCY=1: IDLE->RESP at E, data_out=mem[addr].
- Load without exception, READ_LATENCY>1:
  - IDLE->WAIT at E with the counter loaded to READ_LATENCY-2.
  - WAIT decrements each edge. When the counter is 0, WAIT->RESP and data_out is loaded.
  - resp_valid rises after edge E+READ_LATENCY-1.
- RESP: resp_valid, data_out and exception are held stable until an edge with resp_ready=1. Then RESP->IDLE, resp_valid=0, and req_ready=1 in the following cycle.
- Back-to-back: minimum spacing between accepts is 2 cycles at READ_LATENCY=1 with resp_ready held high.
- Read-after-write to the same address returns the new data. The store completes at its accept edge, before any later request is accepted.
- Async reset mid-WAIT or mid-RESP drops the pending response and returns to IDLE. A store already committed at E persists.
- addr is unsigned. DATA_SIZE need not be a power of two, and comparison is done at full DATA_ADDR_WIDTH.

Decomposition:
- Package data_memory_pkg holds:
  - state encodings ST_IDLE/ST_WAIT/ST_RESP;
  - exception codes EXC_NONE/EXC_RANGE/EXC_BYTE_EN;
  - READ_LATENCY bounds MIN_RD_LAT=1/MAX_RD_LAT=4.
- One sub-module, data_memory_array:
  - DATA_SIZE x DATA_WIDTH storage;
  - synchronous byte-enabled write and combinational read port, indexed by the sampled address.
- data_memory_sync owns the handshake FSM, latency counter, exception check and output registers.

Test Plan:
1. Reset with rst_n=0 for 3 cycles, then release -> req_ready=1, resp_valid=0, data_out=0, exception=00.
2. Store addr=0, data_in=100, byte_en=11, then load addr=0 at READ_LATENCY=2 with resp_ready=1:
   - store: resp_valid one cycle after accept, exception=00;
   - load: data_out=100 exactly 2 cycles after its accept edge.
3. Store 0xABCD to addr 5, then store 0x1234 with byte_en=01, then load addr 5 -> data_out=0xAB34.
4. Load addr=1024 (DATA_SIZE=1024) -> exception=01, data_out=0, response 1 cycle after accept. Store byte_en=00 to addr 3 -> exception=10, and a following load of addr 3 returns its prior value.
5. Backpressure: hold resp_ready=0 for 5 cycles during a load response:
   - resp_valid, data_out and exception stay constant;
   - req_ready stays 0 while req_valid=1 is presented;
   - request accepted only after the response retires.
6. Assert rst_n=0 in the WAIT state of a load at READ_LATENCY=4 -> no resp_valid appears after release, req_ready=1, and earlier stored data is intact.
